rs_cw_corrector: RTL and testbench

- Hardware codeword corrector for the RS(544,514) decoder over GF(2^10).
- Buffers received codewords in NBANK banks and applies the Forney (pos, y) error stream to the buffered symbols by 10-bit XOR.
- Streams the corrected codeword out LANES symbols per beat, with a per-codeword fail flag and correction count.
- Sits after chien_search_forney; in hardware it replaces the bench-side patch-and-compare step.

---
 rtl/rs_cw_pkg.sv | 19 +
 rtl/rs_cw_corrector_bank.sv | 93 +++++++++
 rtl/rs_cw_corrector.sv | 154 +++++++++++++++
 tb/tb_rs_cw_corrector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_cw_pkg.sv
// Shared defaults, width helpers and bank lifecycle states for the RS(544,514)
// codeword corrector.
package rs_cw_pkg;

  localparam int unsigned RS_W     = 10;
  localparam int unsigned RS_N_SYM = 544;
  localparam int unsigned RS_T     = 15;

  function automatic int unsigned pos_width(input int unsigned n_sym);
    return $clog2(n_sym);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n_sym);
    return $clog2(n_sym + 1);
  endfunction

  typedef enum logic [2:0] {EMPTY, FILL, CORR, READY, DRAIN} bank_state_e;

endpackage

// File: rtl/rs_cw_corrector_bank.sv
// One codeword buffer: symbol registers with fill/correct write ports, a beat
// read port, and the per-codeword correction count and fail flag.
module rs_cw_bank
  import rs_cw_pkg::*;
#(
  parameter int unsigned W      = RS_W,
  parameter int unsigned N_SYM  = RS_N_SYM,
  parameter int unsigned T      = RS_T,
  parameter int unsigned LANES  = 4,
  parameter int unsigned POS_W  = pos_width(RS_N_SYM),
  parameter int unsigned CNT_W  = cnt_width(RS_N_SYM),
  parameter int unsigned BEAT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [BEAT_W-1:0]    wr_beat_i,
  input  logic [LANES*W-1:0]   wr_data_i,
  input  logic                 wr_frame_err_i,
  input  logic                 corr_en_i,
  input  logic [POS_W-1:0]     corr_pos_i,
  input  logic [W-1:0]         corr_y_i,
  input  logic                 corr_den_zero_i,
  input  logic                 done_en_i,
  input  logic                 dec_fail_i,
  input  logic [BEAT_W-1:0]    rd_beat_i,
  output logic [LANES*W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]     ncorr_o,
  output logic                 fail_o
);

  logic [W-1:0]     sym [N_SYM];
  logic [POS_W-1:0] rd_base;
  logic [CNT_W-1:0] ncorr_q;
  logic             fail_q;
  logic             pos_bad;

  // Each symbol owns its register so fill and correction decode to a plain
  // per-symbol enable; an out-of-range position simply matches no symbol.
  for (genvar i = 0; i < N_SYM; i++) begin : g_sym
    logic [W-1:0] sym_q;
    always_ff @(posedge clk_i) begin
      if (wr_en_i && wr_beat_i == BEAT_W'(i / LANES)) begin
        sym_q <= wr_data_i[(i % LANES)*W +: W];
      end else if (corr_en_i && corr_pos_i == POS_W'(i)) begin
        sym_q <= sym_q ^ corr_y_i;
      end
    end
    assign sym[i] = sym_q;
  end

  assign rd_base = POS_W'(rd_beat_i) * POS_W'(LANES);

  always_comb begin
    rd_data_o = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rd_data_o[l*W +: W] = sym[rd_base + POS_W'(l)];
    end
  end

  assign pos_bad = {1'b0, corr_pos_i} >= (POS_W+1)'(N_SYM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ncorr_q <= '0;
      fail_q  <= 1'b0;
    end else if (clr_i) begin
      ncorr_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      if (wr_en_i && wr_frame_err_i) begin
        fail_q <= 1'b1;
      end
      if (corr_en_i) begin
        if (ncorr_q != CNT_W'(N_SYM)) begin
          ncorr_q <= ncorr_q + CNT_W'(1);
        end
        // ncorr_q >= T means this correction pushes the count past T
        if (ncorr_q >= CNT_W'(T) || pos_bad || corr_den_zero_i) begin
          fail_q <= 1'b1;
        end
      end
      if (done_en_i && dec_fail_i) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign ncorr_o = ncorr_q;
  assign fail_o  = fail_q;

endmodule

// File: rtl/rs_cw_corrector.sv
// RS(544,514) codeword corrector: rotating fill/correct/drain banks that apply
// the Forney (pos, y) stream to buffered symbols and stream corrected beats out.
module rs_cw_corrector
  import rs_cw_pkg::*;
#(
  parameter int unsigned W     = RS_W,
  parameter int unsigned N_SYM = RS_N_SYM,
  parameter int unsigned T     = RS_T,
  parameter int unsigned LANES = 4,
  parameter int unsigned NBANK = 2,
  parameter int unsigned POS_W = pos_width(N_SYM),
  parameter int unsigned CNT_W = cnt_width(N_SYM)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic [LANES*W-1:0] in_data_i,
  input  logic               in_last_i,
  input  logic               corr_vld_i,
  output logic               corr_rdy_o,
  input  logic [POS_W-1:0]   corr_pos_i,
  input  logic [W-1:0]       corr_y_i,
  input  logic               corr_den_zero_i,
  input  logic               corr_done_i,
  input  logic               dec_fail_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [LANES*W-1:0] out_data_o,
  output logic               out_last_o,
  output logic               out_fail_o,
  output logic [CNT_W-1:0]   out_ncorr_o
);

  localparam int unsigned NBEAT  = N_SYM / LANES;
  localparam int unsigned BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int unsigned PTR_W  = $clog2(NBANK);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  if ((N_SYM % LANES) != 0) begin : g_bad_lanes
    $error("N_SYM must be a multiple of LANES");
  end
  if (NBANK < 2 || (NBANK & (NBANK - 1)) != 0) begin : g_bad_nbank
    $error("NBANK must be a power of two and at least 2");
  end

  bank_state_e        st [NBANK];
  logic [LANES*W-1:0] bank_data  [NBANK];
  logic [CNT_W-1:0]   bank_ncorr [NBANK];
  logic [NBANK-1:0]   bank_fail;

  logic [PTR_W-1:0]  wr_ptr_q, cr_ptr_q, rd_ptr_q;
  logic [BEAT_W-1:0] in_beat_q, out_beat_q;
  logic              run_q;
  logic              in_hs, corr_hs, out_hs, in_final, out_final;

  // run_q keeps the input closed while reset is applied even though bank 0 is EMPTY
  assign in_rdy_o   = run_q && (st[wr_ptr_q] == EMPTY || st[wr_ptr_q] == FILL);
  assign corr_rdy_o = st[cr_ptr_q] == CORR;
  assign out_vld_o  = st[rd_ptr_q] == READY || st[rd_ptr_q] == DRAIN;

  assign in_hs     = in_vld_i && in_rdy_o;
  assign corr_hs   = corr_vld_i && corr_rdy_o;
  assign out_hs    = out_vld_o && out_rdy_i;
  assign in_final  = in_beat_q == LAST_BEAT;
  assign out_final = out_beat_q == LAST_BEAT;

  assign out_data_o  = out_vld_o ? bank_data[rd_ptr_q] : '0;
  assign out_last_o  = out_vld_o && out_final;
  assign out_fail_o  = out_vld_o && bank_fail[rd_ptr_q];
  assign out_ncorr_o = out_vld_o ? bank_ncorr[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      cr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_beat_q  <= '0;
      out_beat_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (in_hs) begin
        in_beat_q <= in_final ? '0 : in_beat_q + BEAT_W'(1);
        if (in_final) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
      end
      if (corr_hs && corr_done_i) begin
        cr_ptr_q <= cr_ptr_q + PTR_W'(1);
      end
      if (out_hs) begin
        out_beat_q <= out_final ? '0 : out_beat_q + BEAT_W'(1);
        if (out_final) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    bank_state_e st_q;
    logic        sel_wr, sel_cr, sel_rd;

    assign sel_wr = wr_ptr_q == PTR_W'(b);
    assign sel_cr = cr_ptr_q == PTR_W'(b);
    assign sel_rd = rd_ptr_q == PTR_W'(b);

    // The three pointers always select banks in distinct states, so at most
    // one of these transitions can target a given bank in a cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q <= EMPTY;
      end else if (sel_wr && in_hs) begin
        st_q <= in_final ? CORR : FILL;
      end else if (sel_cr && corr_hs && corr_done_i) begin
        st_q <= READY;
      end else if (sel_rd && out_hs) begin
        st_q <= out_final ? EMPTY : DRAIN;
      end
    end

    assign st[b] = st_q;

    rs_cw_bank #(
      .W      (W),
      .N_SYM  (N_SYM),
      .T      (T),
      .LANES  (LANES),
      .POS_W  (POS_W),
      .CNT_W  (CNT_W),
      .BEAT_W (BEAT_W)
    ) u_bank (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .clr_i           (sel_rd && out_hs && out_final),
      .wr_en_i         (sel_wr && in_hs),
      .wr_beat_i       (in_beat_q),
      .wr_data_i       (in_data_i),
      .wr_frame_err_i  (in_last_i != in_final),
      .corr_en_i       (sel_cr && corr_hs && !corr_done_i),
      .corr_pos_i      (corr_pos_i),
      .corr_y_i        (corr_y_i),
      .corr_den_zero_i (corr_den_zero_i),
      .done_en_i       (sel_cr && corr_hs && corr_done_i),
      .dec_fail_i      (dec_fail_i),
      .rd_beat_i       (out_beat_q),
      .rd_data_o       (bank_data[b]),
      .ncorr_o         (bank_ncorr[b]),
      .fail_o          (bank_fail[b])
    );
  end

endmodule

// File: tb/tb_rs_cw_corrector.sv
// Directed/randomized bench for rs_cw_corrector against a per-codeword
// reference model of the correction rules.
module tb_rs_cw_corrector;

  localparam int W = 10, NS = 544, TT = 15, LN = 4, NB = NS / LN;
  localparam int NCW = 16, MAXC = 20;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_vld_i = 1'b0, in_last_i = 1'b0;
  logic          in_rdy_o;
  logic [LN*W-1:0] in_data_i = '0;
  logic          corr_vld_i = 1'b0, corr_den_zero_i = 1'b0, corr_done_i = 1'b0, dec_fail_i = 1'b0;
  logic          corr_rdy_o;
  logic [9:0]    corr_pos_i = '0;
  logic [W-1:0]  corr_y_i = '0;
  logic          out_vld_o, out_rdy_i = 1'b0, out_last_o, out_fail_o;
  logic [LN*W-1:0] out_data_o;
  logic [9:0]    out_ncorr_o;

  always #5 clk_i = ~clk_i;

  rs_cw_corrector #(.LANES(LN), .NBANK(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .corr_vld_i(corr_vld_i), .corr_rdy_o(corr_rdy_o), .corr_pos_i(corr_pos_i),
    .corr_y_i(corr_y_i), .corr_den_zero_i(corr_den_zero_i), .corr_done_i(corr_done_i),
    .dec_fail_i(dec_fail_i),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .out_fail_o(out_fail_o), .out_ncorr_o(out_ncorr_o)
  );

  int checks = 0, errors = 0;

  logic [W-1:0] cw      [NCW][NS];
  logic [W-1:0] exp_sym [NCW][NS];
  int  c_pos [NCW][MAXC];
  int  c_y   [NCW][MAXC];
  bit  c_dz  [NCW][MAXC];
  int  c_n [NCW];
  bit  c_df [NCW];
  int  c_lastbeat [NCW];
  bit  exp_fail [NCW];
  int  exp_ncorr [NCW];
  time first_in_t [NCW];
  time last_out_t [NCW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic new_cw(input int id);
    for (int i = 0; i < NS; i++) cw[id][i] = W'($urandom_range(1023, 0));
    c_n[id] = 0;
    c_df[id] = 1'b0;
    c_lastbeat[id] = NB - 1;
  endtask

  task automatic add_corr(input int id, input int pos, input int y, input bit dz);
    c_pos[id][c_n[id]] = pos;
    c_y[id][c_n[id]] = y;
    c_dz[id][c_n[id]] = dz;
    c_n[id]++;
  endtask

  // Reference: corrected symbols, saturating count, and every fail condition.
  task automatic build_exp(input int id);
    int n = 0;
    bit f = c_df[id] || (c_lastbeat[id] != NB - 1);
    for (int i = 0; i < NS; i++) exp_sym[id][i] = cw[id][i];
    for (int k = 0; k < c_n[id]; k++) begin
      if (n < NS) n++;
      if (n > TT) f = 1'b1;
      if (c_dz[id][k]) f = 1'b1;
      if (c_pos[id][k] >= NS) f = 1'b1;
      else exp_sym[id][c_pos[id][k]] ^= W'(c_y[id][k]);
    end
    exp_fail[id] = f;
    exp_ncorr[id] = n;
  endtask

  task automatic send_cw(input int id);
    for (int b = 0; b < NB; b++) begin
      int wt = 0;
      @(negedge clk_i);
      in_vld_i = 1'b1;
      in_last_i = (b == c_lastbeat[id]);
      for (int l = 0; l < LN; l++) in_data_i[l*W +: W] = cw[id][b*LN + l];
      while (!in_rdy_o && wt < 3000) begin
        @(negedge clk_i);
        wt++;
      end
      if (!in_rdy_o) begin
        chk($sformatf("in_tmo cw%0d b%0d", id, b), in_rdy_o, 1);
        in_vld_i = 1'b0;
        return;
      end
      if (b == 0) first_in_t[id] = $time;
    end
    @(negedge clk_i);
    in_vld_i = 1'b0;
    in_last_i = 1'b0;
  endtask

  task automatic send_corr(input int id);
    for (int k = 0; k <= c_n[id]; k++) begin
      int wt = 0;
      @(negedge clk_i);
      corr_vld_i = 1'b1;
      if (k < c_n[id]) begin
        corr_done_i = 1'b0;
        corr_pos_i = 10'(c_pos[id][k]);
        corr_y_i = W'(c_y[id][k]);
        corr_den_zero_i = c_dz[id][k];
        dec_fail_i = 1'b0;
      end else begin
        corr_done_i = 1'b1;
        corr_pos_i = 10'($urandom_range(543, 0));
        corr_y_i = W'($urandom_range(1023, 1));
        corr_den_zero_i = 1'b0;
        dec_fail_i = c_df[id];
      end
      while (!corr_rdy_o && wt < 3000) begin
        @(negedge clk_i);
        wt++;
      end
      if (!corr_rdy_o) begin
        chk($sformatf("corr_tmo cw%0d k%0d", id, k), corr_rdy_o, 1);
        corr_vld_i = 1'b0;
        return;
      end
    end
    @(negedge clk_i);
    corr_vld_i = 1'b0;
    corr_done_i = 1'b0;
    dec_fail_i = 1'b0;
  endtask

  task automatic recv_cw(input int id, input int pct, input int nbeats);
    int beat = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [LN*W-1:0] ed;
    while (beat < nbeats && cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
      if (stalled) chk($sformatf("hold_vld cw%0d b%0d", id, beat), out_vld_o, 1);
      if (out_vld_o) begin
        for (int l = 0; l < LN; l++) ed[l*W +: W] = exp_sym[id][beat*LN + l];
        chk($sformatf("data cw%0d b%0d", id, beat), out_data_o, ed);
        chk($sformatf("last cw%0d b%0d", id, beat), out_last_o, (beat == NB - 1));
        chk($sformatf("fail cw%0d b%0d", id, beat), out_fail_o, exp_fail[id]);
        chk($sformatf("ncorr cw%0d b%0d", id, beat), out_ncorr_o, exp_ncorr[id]);
        stalled = ($urandom_range(99, 0) >= pct);
        out_rdy_i = !stalled;
        if (!stalled) begin
          if (beat == NB - 1) last_out_t[id] = $time;
          beat++;
        end
      end else begin
        stalled = 1'b0;
        out_rdy_i = 1'b0;
      end
    end
    chk($sformatf("out_beats cw%0d", id), beat, nbeats);
    @(negedge clk_i);
    out_rdy_i = 1'b0;
  endtask

  task automatic run_single(input int id, input int pct);
    build_exp(id);
    send_cw(id);
    send_corr(id);
    recv_cw(id, pct, NB);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst in_rdy", in_rdy_o, 0);
    chk("rst corr_rdy", corr_rdy_o, 0);
    chk("rst out_vld", out_vld_o, 0);
    chk("rst out_data", out_data_o, 0);
    chk("rst out_last", out_last_o, 0);
    chk("rst out_fail", out_fail_o, 0);
    chk("rst out_ncorr", out_ncorr_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("post_rst in_rdy", in_rdy_o, 1);

    // Two errors, full-rate drain, nothing beyond the last beat
    new_cw(0);
    add_corr(0, 3, 'h155, 0);
    add_corr(0, 500, 'h0AA, 0);
    run_single(0, 100);
    @(negedge clk_i);
    chk("no_extra cw0", out_vld_o, 0);

    // Back-to-back zero-error codewords A,B,C
    for (int i = 1; i <= 3; i++) begin
      new_cw(i);
      build_exp(i);
    end
    fork
      begin for (int i = 1; i <= 3; i++) send_cw(i); end
      begin for (int i = 1; i <= 3; i++) send_corr(i); end
      begin for (int i = 1; i <= 3; i++) recv_cw(i, 100, NB); end
    join
    chk("c_waits_for_a", first_in_t[3] > last_out_t[1], 1);

    // T+1 corrections
    new_cw(4);
    for (int k = 0; k < TT + 1; k++) add_corr(4, k*30 + $urandom_range(29, 0), $urandom_range(1023, 1), 0);
    run_single(4, 100);
    // Out-of-range position
    new_cw(5);
    add_corr(5, 20, $urandom_range(1023, 1), 0);
    add_corr(5, 600, 'h3FF, 0);
    run_single(5, 100);
    // Zero Forney denominator still applies the XOR
    new_cw(6);
    add_corr(6, 10, $urandom_range(1023, 1), 1);
    run_single(6, 100);
    // Repeated position
    new_cw(7);
    add_corr(7, 7, 'h3FF, 0);
    add_corr(7, 7, 'h001, 0);
    run_single(7, 100);
    chk("pos7 model", exp_sym[7][7] ^ cw[7][7], 'h3FE);

    // Backpressure while the next bank fills
    for (int i = 8; i <= 9; i++) begin
      new_cw(i);
      for (int k = 0; k < int'($urandom_range(5, 0)); k++)
        add_corr(i, $urandom_range(NS - 1, 0), $urandom_range(1023, 1), 0);
      build_exp(i);
    end
    fork
      begin send_cw(8); send_cw(9); end
      begin send_corr(8); send_corr(9); end
      begin recv_cw(8, 30, NB); recv_cw(9, 30, NB); end
    join

    // Framing error: in_last on beat 100 only
    new_cw(10);
    c_lastbeat[10] = 100;
    run_single(10, 100);
    // Upstream decoder failure
    new_cw(11);
    add_corr(11, $urandom_range(NS - 1, 0), $urandom_range(1023, 1), 0);
    c_df[11] = 1'b1;
    run_single(11, 70);

    // Reset in the middle of a drain
    new_cw(12);
    add_corr(12, 1, 'h011, 0);
    add_corr(12, 2, 'h022, 1);
    add_corr(12, 543, 'h033, 0);
    build_exp(12);
    send_cw(12);
    send_corr(12);
    recv_cw(12, 100, 50);
    @(negedge clk_i);
    chk("pre_rst out_vld", out_vld_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst out_vld", out_vld_o, 0);
    chk("mid_rst out_data", out_data_o, 0);
    chk("mid_rst out_last", out_last_o, 0);
    chk("mid_rst out_fail", out_fail_o, 0);
    chk("mid_rst out_ncorr", out_ncorr_o, 0);
    chk("mid_rst in_rdy", in_rdy_o, 0);
    chk("mid_rst corr_rdy", corr_rdy_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    new_cw(13);
    for (int k = 0; k < 4; k++) add_corr(13, k*100 + 5, $urandom_range(1023, 1), 0);
    run_single(13, 50);
    @(negedge clk_i);
    chk("no_extra cw13", out_vld_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
